// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter for the single-port data RAM with hold-limited locked bursts
// Optional DMEM_ARB_RR_EN selects round-robin contention; undefined gives fixed priority to master 0.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

  localparam logic [7:0] MAX_LCNT = 8'(MAX_LOCK);

  owner_t     owner;
  logic [7:0] lcnt;
  logic [7:0] lcnt_nxt;
  logic [1:0] rd_tag;
  logic       gnt0;
  logic       gnt1;
  logic       m0_wins;
  logic       own_is1;
  logic       own_req;
  logic       own_lock;
  logic       forced;

`ifdef DMEM_ARB_RR_EN
  logic rr_last;

  // The master not recorded in rr_last wins a contended cycle.
  assign m0_wins = rr_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (gnt0) begin
      rr_last <= 1'b0;
    end else if (gnt1) begin
      rr_last <= 1'b1;
    end
  end
`else
  logic fr_hold0;

  // After master 0 hits the hold limit, master 1 wins the next contended cycle.
  assign m0_wins = !fr_hold0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fr_hold0 <= 1'b0;
    end else begin
      fr_hold0 <= forced && (owner == OWN_P0);
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (owner)
        OWN_P0:  gnt0 = m0_req;
        OWN_P1:  gnt1 = m1_req;
        default: begin
          if (m0_req && m1_req) begin
            gnt0 = m0_wins;
            gnt1 = !m0_wins;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
      endcase
    end
  end

  assign own_is1  = (owner == OWN_P1);
  assign own_req  = own_is1 ? m1_req : m0_req;
  assign own_lock = own_is1 ? m1_lock : m0_lock;
  assign lcnt_nxt = lcnt + 8'd1;
  // Under ownership the owner's req implies its grant, so req & lock is a granted locked access.
  assign forced   = (owner != OWN_NONE) && own_req && own_lock && (lcnt_nxt == MAX_LCNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= OWN_NONE;
      lcnt   <= 8'd0;
      rd_tag <= 2'b00;
    end else begin
      rd_tag <= {gnt1 && !m1_we, gnt0 && !m0_we};
      case (owner)
        OWN_NONE: begin
          if (gnt0 && m0_lock) begin
            owner <= OWN_P0;
            lcnt  <= 8'd1;
          end else if (gnt1 && m1_lock) begin
            owner <= OWN_P1;
            lcnt  <= 8'd1;
          end
        end
        default: begin
          if (!own_req || !own_lock || forced) begin
            owner <= OWN_NONE;
            lcnt  <= 8'd0;
          end else begin
            lcnt  <= lcnt_nxt;
          end
        end
      endcase
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_wea   = (gnt0 && m0_we) || (gnt1 && m1_we);
  assign mem_addr  = gnt1 ? m1_addr : m0_addr;
  assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;
  // Reset also masks a read tag captured before reset was asserted.
  assign m0_rvalid = rd_tag[0] && !rst;
  assign m1_rvalid = rd_tag[1] && !rst;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural data RAM
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [9:0]  m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [9:0]  m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wea;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] ram [0:1023];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_wea) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  dmem_arbiter #(.AW(10), .DW(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock, input logic [9:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock, input logic [9:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wd;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
  endtask

  task automatic test_reset();
    tick();
    ld_en = 1'b1; ld_addr = 10'h010; ld_data = 32'hDEADBEEF;
    drv0(1'b1, 1'b1, 1'b0, 10'h001, 32'h1);
    drv1(1'b1, 1'b1, 1'b1, 10'h002, 32'h2);
    @(negedge clk);
    tests_run++; if (m0_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); end
    tests_run++; if (m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_m1_gnt: got %b want 0", m1_gnt); end
    tests_run++; if (mem_wea !== 1'b0) begin tests_failed++; $display("FAIL rst_wea: got %b want 0", mem_wea); end
    tests_run++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_rvalid: got %b%b want 00", m1_rvalid, m0_rvalid); end
    tick();
    ld_en = 1'b0; rst = 1'b0;
    idle();
    @(negedge clk);
    tests_run++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL post_rst_rvalid: got %b%b want 00", m1_rvalid, m0_rvalid); end
  endtask

  task automatic test_single_read();
    tick();
    drv0(1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
    @(negedge clk);
    tests_run++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL rd_gnt: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt); end
    tests_run++; if (mem_addr !== 10'h010) begin tests_failed++; $display("FAIL rd_addr: got %h want 010", mem_addr); end
    tick();
    idle();
    @(negedge clk);
    tests_run++; if (m0_rvalid !== 1'b1) begin tests_failed++; $display("FAIL rd_rvalid: got %b want 1", m0_rvalid); end
    tests_run++; if (m0_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_rdata: got %h want deadbeef", m0_rdata); end
    tests_run++; if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_m1_rvalid: got %b want 0", m1_rvalid); end
    tick();
    @(negedge clk);
    tests_run++; if (m0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid_once: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_write_read();
    tick();
    drv1(1'b1, 1'b1, 1'b0, 10'h3FF, 32'h12345678);
    @(negedge clk);
    tests_run++; if (m1_gnt !== 1'b1 || mem_wea !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt_wea: got gnt=%b wea=%b want 1 1", m1_gnt, mem_wea); end
    tests_run++; if (mem_addr !== 10'h3FF || mem_wdata !== 32'h12345678) begin tests_failed++; $display("FAIL wr_bus: got %h/%h want 3ff/12345678", mem_addr, mem_wdata); end
    tick();
    drv1(1'b1, 1'b0, 1'b0, 10'h3FF, 32'h0);
    @(negedge clk);
    tests_run++; if (m1_gnt !== 1'b1 || mem_wea !== 1'b0) begin tests_failed++; $display("FAIL wr_rd_gnt: got gnt=%b wea=%b want 1 0", m1_gnt, mem_wea); end
    tests_run++; if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_no_rvalid: got %b want 0", m1_rvalid); end
    tick();
    idle();
    @(negedge clk);
    tests_run++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL wr_readback: got v=%b d=%h want 1 12345678", m1_rvalid, m1_rdata); end
    tests_run++; if (m0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_m0_rvalid: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_contention();
    logic e0, e1;
    e0 = 1'b0; e1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      drv0(1'b1, 1'b0, 1'b0, 10'h020, 32'h0);
      drv1(1'b1, 1'b0, 1'b0, 10'h021, 32'h0);
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      e0 = (k % 2 == 0);
      e1 = !e0;
`else
      e0 = 1'b1;
      e1 = 1'b0;
`endif
      tests_run++; if (m0_gnt !== e0 || m1_gnt !== e1) begin tests_failed++; $display("FAIL cont_%0d: got m0=%b m1=%b want m0=%b m1=%b", k, m0_gnt, m1_gnt, e0, e1); end
    end
    tick();
    idle();
    @(negedge clk);
    tests_run++; if (m0_rvalid !== e0 || m1_rvalid !== e1) begin tests_failed++; $display("FAIL cont_rvalid: got m0=%b m1=%b want m0=%b m1=%b", m0_rvalid, m1_rvalid, e0, e1); end
  endtask

  task automatic test_locked_burst();
    for (int k = 0; k < 5; k++) begin
      tick();
      drv1(1'b1, 1'b0, 1'b1, 10'(10'h100 + k), 32'h0);
      if (k > 0) drv0(1'b1, 1'b0, 1'b0, 10'h030, 32'h0);
      @(negedge clk);
      if (k < 4) begin
        tests_run++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst1_%0d: got m0=%b m1=%b want m0=0 m1=1", k, m0_gnt, m1_gnt); end
      end else begin
        tests_run++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst1_release: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt); end
      end
    end
    tick();
    idle();
  endtask

  task automatic test_forced_release();
    for (int k = 0; k < 6; k++) begin
      tick();
      drv0(1'b1, 1'b0, 1'b1, 10'(10'h200 + k), 32'h0);
      if (k > 0) drv1(1'b1, 1'b0, 1'b0, 10'h040, 32'h0);
      @(negedge clk);
      if (k < 4) begin
        tests_run++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst0_%0d: got m0=%b m1=%b want m0=1 m1=0", k, m0_gnt, m1_gnt); end
      end else if (k == 4) begin
        tests_run++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst0_block: got m0=%b m1=%b want m0=0 m1=1", m0_gnt, m1_gnt); end
      end else begin
        tests_run++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst0_after: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt); end
      end
    end
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      drv0(1'b1, 1'b0, 1'b1, 10'(10'h220 + k), 32'h0);
      @(negedge clk);
      tests_run++; if (m0_gnt !== 1'b1) begin tests_failed++; $display("FAIL reacquire_%0d: got m0=%b want 1", k, m0_gnt); end
    end
    tick();
    idle();
  endtask

  task automatic test_early_release();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) drv0(1'b1, 1'b0, (k < 2), 10'(10'h050 + k), 32'h0);
      else drv0(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
      if (k > 0) drv1(1'b1, 1'b0, 1'b0, 10'h060, 32'h0);
      @(negedge clk);
      if (k < 3) begin
        tests_run++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL early_%0d: got m0=%b m1=%b want m0=1 m1=0", k, m0_gnt, m1_gnt); end
      end else begin
        tests_run++; if (m1_gnt !== 1'b1) begin tests_failed++; $display("FAIL early_m1: got m1=%b want 1", m1_gnt); end
      end
    end
    tick();
    idle();
  endtask

  task automatic test_req_drop();
    tick();
    drv1(1'b1, 1'b0, 1'b1, 10'h070, 32'h0);
    @(negedge clk);
    tests_run++; if (m1_gnt !== 1'b1) begin tests_failed++; $display("FAIL drop_acq: got m1=%b want 1", m1_gnt); end
    tick();
    drv1(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    drv0(1'b1, 1'b0, 1'b0, 10'h071, 32'h0);
    @(negedge clk);
    tests_run++; if (m0_gnt !== 1'b0) begin tests_failed++; $display("FAIL drop_holdoff: got m0=%b want 0", m0_gnt); end
    tick();
    @(negedge clk);
    tests_run++; if (m0_gnt !== 1'b1) begin tests_failed++; $display("FAIL drop_m0: got m0=%b want 1", m0_gnt); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    tick();
    drv1(1'b1, 1'b0, 1'b1, 10'h080, 32'h0);
    @(negedge clk);
    tests_run++; if (m1_gnt !== 1'b1) begin tests_failed++; $display("FAIL rmid_acq: got m1=%b want 1", m1_gnt); end
    tick();
    drv1(1'b1, 1'b0, 1'b1, 10'h081, 32'h0);
    drv0(1'b1, 1'b0, 1'b0, 10'h090, 32'h0);
    @(negedge clk);
    tests_run++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin tests_failed++; $display("FAIL rmid_owned: got m0=%b m1=%b want m0=0 m1=1", m0_gnt, m1_gnt); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL rmid_gnt: got m0=%b m1=%b want 0 0", m0_gnt, m1_gnt); end
    tests_run++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rmid_rvalid: got m0=%b m1=%b want 0 0", m0_rvalid, m1_rvalid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL rmid_first: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt); end
    tests_run++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rmid_no_rvalid: got m0=%b m1=%b want 0 0", m0_rvalid, m1_rvalid); end
    tick();
    idle();
    @(negedge clk);
    tests_run++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rmid_rd: got m0=%b m1=%b want m0=1 m1=0", m0_rvalid, m1_rvalid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_locked_burst();
    test_forced_release();
    test_early_release();
    test_req_drop();
    test_reset_mid();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
